// File: rtl/alu_mc_if.sv
// Request/response bundle for the alu_mc execute-stage ALU.
// The master modport drives operations in and takes results; the slave modport is the ALU.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, alu_ctrl, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_ctrl, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/shift/compare ops, plus iterative MUL/MULHU/DIVU/REMU.
// The iterative ops are built only when ALU_MULDIV_EN is defined; otherwise opcodes A-D return 0.
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;

`ifdef ALU_MULDIV_EN
  localparam int unsigned CNT_W   = SHW + 1;
  localparam logic [3:0]  OP_MUL  = 4'hA;
  localparam logic [3:0]  OP_REMU = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_e;
`endif

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;

  assign shamt = bus.b[SHW-1:0];

  // Single-cycle result; reserved opcodes fall through to zero.
  always_comb begin
    sc_res = '0;
    case (bus.alu_ctrl)
      OP_ADD:  sc_res = bus.a + bus.b;
      OP_SUB:  sc_res = bus.a - bus.b;
      OP_AND:  sc_res = bus.a & bus.b;
      OP_OR:   sc_res = bus.a | bus.b;
      OP_XOR:  sc_res = bus.a ^ bus.b;
      OP_SLL:  sc_res = bus.a << shamt;
      OP_SRL:  sc_res = bus.a >> shamt;
      OP_SRA:  sc_res = $unsigned($signed(bus.a) >>> shamt);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      default: sc_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               sel_hi_q, sel_hi_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH-1:0]   div_sub;
  logic               div_ge;
  logic               is_iter;
  logic [WIDTH-1:0]   iter_res;

  assign is_iter = (bus.alu_ctrl >= OP_MUL) && (bus.alu_ctrl <= OP_REMU);

  // One bit step: shift-add multiply (LSB first) or restoring divide (MSB first).
  // Both start from {0, a}; multiply ends as {hi, lo}, divide as {remainder, quotient}.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    div_rem = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge  = (div_rem >= {1'b0, opb_q});
    div_sub = div_rem[WIDTH-1:0] - opb_q;
    if (is_div_q) begin
      acc_step = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                        : {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  assign iter_res = sel_hi_q ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
`ifdef ALU_MULDIV_EN
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    opb_d       = opb_q;
    is_div_d    = is_div_q;
    sel_hi_d    = sel_hi_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          in_ready_d = 1'b0;
`ifdef ALU_MULDIV_EN
          if (is_iter) begin
            state_d  = S_BUSY;
            acc_d    = {{WIDTH{1'b0}}, bus.a};
            cnt_d    = CNT_W'(WIDTH);
            opb_d    = bus.b;
            is_div_d = bus.alu_ctrl[2];
            sel_hi_d = bus.alu_ctrl[0];
          end else
`endif
          begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            result_d    = sc_res;
            zero_d      = (sc_res == '0);
          end
        end
      end
`ifdef ALU_MULDIV_EN
      S_BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          result_d    = iter_res;
          zero_d      = (iter_res == '0);
        end
      end
`endif
      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
`ifdef ALU_MULDIV_EN
      acc_q       <= '0;
      cnt_q       <= '0;
      opb_q       <= '0;
      is_div_q    <= 1'b0;
      sel_hi_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
`ifdef ALU_MULDIV_EN
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      opb_q       <= opb_d;
      is_div_q    <= is_div_d;
      sel_hi_q    <= sel_hi_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32) against an arithmetic reference model.
// Expectations for opcodes A-D follow ALU_MULDIV_EN, matching the build of the design.
module tb_alu_mc;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_mc_if #(.WIDTH(W)) bus();

  alu_mc #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic [4:0]  sh;
    p  = {32'd0, x} * {32'd0, y};
    sh = y[4:0];
    case (op)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h2: return x & y;
      4'h3: return x | y;
      4'h4: return x ^ y;
      4'h5: return x << sh;
      4'h6: return x >> sh;
      4'h7: return $unsigned($signed(x) >>> sh);
      4'h8: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'h9: return (x < y) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
      4'hA: return p[31:0];
      4'hB: return p[63:32];
      4'hC: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      4'hD: return (y == 32'd0) ? x : x % y;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
    if (op >= 4'hA && op <= 4'hD) return W + 1;
`endif
    return 1;
  endfunction

  // Drives one transaction with out_ready=1; lat counts edges from acceptance to out_valid (-1 on timeout).
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output logic z, output int lat, output logic rdy_after);
    @(negedge clk);
    bus.alu_ctrl  = op;
    bus.a         = x;
    bus.b         = y;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy_after     = bus.in_ready;
    bus.in_valid  = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus.alu_ctrl  = 4'($urandom);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      if (bus.out_valid) begin
        lat = i;
        break;
      end
      bus.in_valid = 1'($urandom);
      @(negedge clk);
    end
    res = bus.result;
    z   = bus.zero;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    checks++; if (bus.zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", bus.zero); end
  endtask

  task automatic test_sweep();
    logic [31:0] exp_tab [10] = '{32'h0C, 32'h08, 32'h02, 32'h0A, 32'h08, 32'h28, 32'h02, 32'h02, 32'h0, 32'h0};
    logic [31:0] res;
    logic        z, rdy;
    int          lat;
    for (int op = 0; op < 10; op++) begin
      run_op(4'(op), 32'h0A, 32'h02, res, z, lat, rdy);
      checks++; if (res !== exp_tab[op]) begin errors++; $display("FAIL sweep_op%0d_result: got %h expected %h", op, res, exp_tab[op]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL sweep_op%0d_latency: got %0d expected 1", op, lat); end
      checks++; if (z !== (exp_tab[op] == 32'd0)) begin errors++; $display("FAIL sweep_op%0d_zero: got %b expected %b", op, z, exp_tab[op] == 32'd0); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL sweep_op%0d_in_ready_drop: got %b expected 0", op, rdy); end
    end
  endtask

  task automatic test_all_ones();
    logic [3:0]  ops  [6] = '{4'h0, 4'h1, 4'h8, 4'h7, 4'hA, 4'hB};
    logic [31:0] bs   [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1F, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`ifdef ALU_MULDIV_EN
    logic [31:0] exps [6] = '{32'hFFFF_FFFE, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE};
    int          lats [6] = '{1, 1, 1, 1, 33, 33};
`else
    logic [31:0] exps [6] = '{32'hFFFF_FFFE, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
    int          lats [6] = '{1, 1, 1, 1, 1, 1};
`endif
    logic [31:0] res;
    logic        z, rdy;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], 32'hFFFF_FFFF, bs[i], res, z, lat, rdy);
      checks++; if (res !== exps[i]) begin errors++; $display("FAIL ones_op%h_result: got %h expected %h", ops[i], res, exps[i]); end
      checks++; if (z !== (exps[i] == 32'd0)) begin errors++; $display("FAIL ones_op%h_zero: got %b expected %b", ops[i], z, exps[i] == 32'd0); end
      checks++; if (lat !== lats[i]) begin errors++; $display("FAIL ones_op%h_latency: got %0d expected %0d", ops[i], lat, lats[i]); end
    end
  endtask

  task automatic test_divide();
    logic [3:0]  ops  [4] = '{4'hC, 4'hD, 4'hC, 4'hD};
    logic [31:0] as   [4] = '{32'd100, 32'd100, 32'd5, 32'd5};
    logic [31:0] bs   [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
`ifdef ALU_MULDIV_EN
    logic [31:0] exps [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5};
`else
    logic [31:0] exps [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
    logic [31:0] res;
    logic        z, rdy;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, z, lat, rdy);
      checks++; if (res !== exps[i]) begin errors++; $display("FAIL div_%0d_result: got %h expected %h", i, res, exps[i]); end
      checks++; if (lat !== exp_lat(ops[i])) begin errors++; $display("FAIL div_%0d_latency: got %0d expected %0d", i, lat, exp_lat(ops[i])); end
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] x, y, res, e;
    logic        z, rdy;
    int          lat;
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(0, 40));
        default: y = $urandom;
      endcase
      e = model(op, x, y);
      run_op(op, x, y, res, z, lat, rdy);
      checks++; if (res !== e) begin errors++; $display("FAIL rand_%0d_op%h_result: a=%h b=%h got %h expected %h", n, op, x, y, res, e); end
      checks++; if (z !== (e == 32'd0)) begin errors++; $display("FAIL rand_%0d_zero: got %b expected %b", n, z, e == 32'd0); end
      checks++; if (lat !== exp_lat(op)) begin errors++; $display("FAIL rand_%0d_latency: got %0d expected %0d", n, lat, exp_lat(op)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    e = 32'h0000_1235;
    @(negedge clk);
    bus.alu_ctrl  = 4'h0;
    bus.a         = 32'h1234;
    bus.b         = 32'h1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid: got %b expected 1", bus.out_valid); end
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a        = $urandom;
      @(negedge clk);
      checks++; if (bus.result !== e) begin errors++; $display("FAIL bp_hold_%0d_result: got %h expected %h", c, bus.result, e); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d_in_ready: got %b expected 0", c, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_%0d_out_valid: got %b expected 1", c, bus.out_valid); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_second_accept: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    logic        z, rdy, seen;
    int          lat;
    @(negedge clk);
    bus.alu_ctrl  = 4'hC;
    bus.a         = 32'd1000;
    bus.b         = 32'd3;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", bus.out_valid); end
    @(negedge clk);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_late_valid: got %b expected 0", seen); end
    run_op(4'h0, 32'd1, 32'd1, res, z, lat, rdy);
    checks++; if (res !== 32'd2) begin errors++; $display("FAIL abort_next_add: got %h expected 2", res); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL abort_next_latency: got %0d expected 1", lat); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = 4'h0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_sweep();
    test_all_ones();
    test_divide();
    test_random();
    test_backpressure();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
